ldst_control_unit: RTL and testbench
====================================

// Module: ldst_control_unit
// PURPOSE
//  Hardwired control sequencer for the Mini-SRC datapath: drives the datapath control strobes for fetch and for the ld / ldi / st
//  memory-reference instructions, plus nop and halt. Sits beside Datapath; consumes IR and a memory acknowledge, produces all strobes.
//  Adds a Read/Write wait handshake with timeout so slower memory models can be attached.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles a Read/Write state waits for mem_ack before faulting (1..255)
//  OPC_W        5   opcode field width, ir[31:27]
// PORTS
//  clock        in   1   system clock, all state on posedge
//  clear        in   1   asynchronous active-low reset
//  ir           in   32  instruction register contents from Datapath
//  mem_ack      in   1   memory completed current Read/Write this cycle
//  stop         in   1   request halt at next instruction boundary
//  PCout,Zlowout,MDRout,BAout,Cout,Rout            out 1 each  bus-driver selects
//  PCin,MARin,MDRin,IRin,Yin,Zlowin,Rin            out 1 each  register load enables
//  IncPC,Read,Write,Gra,Grb                        out 1 each  PC increment, memory strobes, register-field selects
//  alu_add      out  1   ALU operation select = ADD (asserted with Zlowin)
//  run          out  1   1 while executing; 0 in reset and HALT
//  mem_err      out  1   sticky: memory timeout occurred
//  illegal_op   out  1   one-cycle pulse on unsupported opcode
// BEHAVIOUR
//  - Moore machine: every strobe is a pure decode of the state register; no strobe depends combinationally on ir/mem_ack.
//  - clear=0: state=RST, all outputs 0 (run=0, mem_err=0) immediately, independent of clock; mid-instruction reset aborts with no
//    residual strobe. First posedge after clear=1 -> T0.
//  - Strobes per state (unlisted = 0):
//    T0: PCout MARin IncPC PCin | T1: Read MDRin | T2: MDRout IRin | T3: Grb BAout Yin | T4: Cout alu_add Zlowin
//    LD5: Zlowout MARin | LD6: Read MDRin | LD7: MDRout Gra Rin
//    LDI5: Zlowout Gra Rin
//    ST5: Zlowout MARin | ST6: Gra Rout MDRin | ST7: Write
//  - Transitions: T0->T1->T2->T3. At end of T3 (IR valid): opcode nop(11010)->T0; halt(11011)->HALT;
//    ld(00000)/ldi(00001)/st(00010)->T4; any other -> T0 with illegal_op=1 for the T0 cycle. End of T4: ld->LD5, ldi->LDI5, st->ST5.
//    LD5->LD6->LD7, ST5->ST6->ST7. Last step (LD7, LDI5, ST7, nop T3): stop=1 -> HALT, else -> T0.
//  - Wait states T1, LD6, ST7: remain while mem_ack=0, strobes held constant; advance on first posedge with mem_ack=1.
//    mem_ack outside wait states is ignored.
//  - Wait counter: cleared on entry to each wait state, increments each stall cycle; when stall count reaches MEM_TIMEOUT
//    with mem_ack still 0 -> HALT, mem_err=1. mem_ack=1 in the same cycle as limit: ack wins, no fault.
//  - HALT: all strobes 0, run=0; exit only via clear. mem_err cleared only by clear.
//  - Fetch latency with mem_ack tied 1: ld 8 cycles, ldi 6, st 8, nop 4.
// STRUCTURE
//  - Shared include mini_src_defs.vh: opcode constants (OP_LD, OP_LDI, OP_ST, OP_NOP, OP_HALT), state encoding localparams,
//    IR field positions (opcode 31:27, Ra 26:23, Rb 22:19, C 18:0).
//  - Sub-module mem_wait_timer: counter with clr/inc/expired, width $clog2(MEM_TIMEOUT+1), async active-low clear.
//  - Top: state register + next-state logic + output decode case.
// TESTING
//  1. ld R1,0x55(R2): ir=32'h0090_0055, mem_ack=1 -> states T0..T2,T3,T4,LD5,LD6,LD7, each strobe set exactly as table, back in T0 at cycle 9.
//  2. ldi R3,0x10(R0): ir=32'h0980_0010 -> LDI5 asserts Zlowout,Gra,Rin; Read never asserted after T1; T0 at cycle 7.
//  3. st 0x20(R4),R5: ir=32'h12A0_0020 -> ST6 Gra,Rout,MDRin with Read=0; ST7 Write=1 for exactly one cycle.
//  4. mem_ack low 3 cycles in T1 -> Read,MDRin held 4 cycles, IRin not asserted until the cycle after ack.
//  5. mem_ack never asserted in LD6 -> after 15 stall cycles state HALT, mem_err=1, run=0, all strobes 0; stays until clear.
//  6. halt ir=32'hD800_0000 -> HALT after T3; separately clear=0 pulsed mid-LD6 -> all outputs 0 before next edge, restart at T0.

Source files
------------

// File: rtl/ldst_control_unit_pkg.sv
// rtl/ldst_control_unit_pkg.sv - state encoding, opcodes and helpers for the ld/ldi/st control sequencer
package ldst_control_unit_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_LD5,
        S_LD6,
        S_LD7,
        S_LDI5,
        S_ST5,
        S_ST6,
        S_ST7,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // States that stall on the memory acknowledge
    function automatic logic is_wait_state(input state_t s);
        return (s == S_T1) || (s == S_LD6) || (s == S_ST7);
    endfunction

endpackage

// File: rtl/ldst_control_unit_mem_wait_timer.sv
// rtl/ldst_control_unit_mem_wait_timer.sv - stall-cycle counter flagging the last allowed stall cycle
module ldst_control_unit_mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // High during the stall cycle that would bring the count to LIMIT
    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/ldst_control_unit.sv
// rtl/ldst_control_unit.sv - Moore control sequencer for fetch, ld, ldi, st, nop and halt
module ldst_control_unit
    import ldst_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPC_W       = 5
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        BAout,
    output logic        Cout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Rin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        alu_add,
    output logic        run,
    output logic        mem_err,
    output logic        illegal_op
);

    state_t state, state_nxt;
    logic   set_err, set_ill, expired, in_wait;
    logic   op_ld, op_ldi, op_st, op_nop, op_halt;
    logic [OPC_W-1:0] opcode;
    logic   unused_ir;

    assign opcode    = ir[31 -: OPC_W];
    assign unused_ir = ^ir[31-OPC_W:0];
    assign op_ld     = (opcode == OPC_W'(OP_LD));
    assign op_ldi    = (opcode == OPC_W'(OP_LDI));
    assign op_st     = (opcode == OPC_W'(OP_ST));
    assign op_nop    = (opcode == OPC_W'(OP_NOP));
    assign op_halt   = (opcode == OPC_W'(OP_HALT));
    assign in_wait   = is_wait_state(state);

    ldst_control_unit_mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk     (clock),
        .rst_n   (clear),
        .clr     (!in_wait),
        .inc     (in_wait && !mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= S_RST;
            mem_err    <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_nxt;
            illegal_op <= set_ill;
            if (set_err) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        set_ill   = 1'b0;
        case (state)
            S_RST:  state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1, S_LD6: begin
                if (mem_ack) begin
                    state_nxt = (state == S_T1) ? S_T2 : S_LD7;
                end else if (expired) begin
                    state_nxt = S_HALT;
                    set_err   = 1'b1;
                end
            end
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                if (op_nop) begin
                    state_nxt = stop ? S_HALT : S_T0;
                end else if (op_halt) begin
                    state_nxt = S_HALT;
                end else if (op_ld || op_ldi || op_st) begin
                    state_nxt = S_T4;
                end else begin
                    state_nxt = S_T0;
                    set_ill   = 1'b1;
                end
            end
            S_T4: begin
                if (op_ld)       state_nxt = S_LD5;
                else if (op_ldi) state_nxt = S_LDI5;
                else if (op_st)  state_nxt = S_ST5;
                else             state_nxt = S_T0;
            end
            S_LD5:  state_nxt = S_LD6;
            S_LD7, S_LDI5: state_nxt = stop ? S_HALT : S_T0;
            S_ST5:  state_nxt = S_ST6;
            S_ST6:  state_nxt = S_ST7;
            S_ST7: begin
                if (mem_ack) begin
                    state_nxt = stop ? S_HALT : S_T0;
                end else if (expired) begin
                    state_nxt = S_HALT;
                    set_err   = 1'b1;
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        {PCout, Zlowout, MDRout, BAout, Cout, Rout} = '0;
        {PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin} = '0;
        {IncPC, Read, Write, Gra, Grb, alu_add} = '0;
        run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0:   begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
            S_T1:   begin Read = 1'b1; MDRin = 1'b1; end
            S_T2:   begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            S_T4:   begin Cout = 1'b1; alu_add = 1'b1; Zlowin = 1'b1; end
            S_LD5:  begin Zlowout = 1'b1; MARin = 1'b1; end
            S_LD6:  begin Read = 1'b1; MDRin = 1'b1; end
            S_LD7:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_LDI5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_ST5:  begin Zlowout = 1'b1; MARin = 1'b1; end
            S_ST6:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            S_ST7:  begin Write = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldst_control_unit.sv
// tb/tb_ldst_control_unit.sv - directed table-driven bench for ldst_control_unit
module tb_ldst_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ack = 1'b0;
    logic        stop = 1'b0;
    logic PCout, Zlowout, MDRout, BAout, Cout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin;
    logic IncPC, Read, Write, Gra, Grb, alu_add;
    logic run, mem_err, illegal_op;
    logic [18:0] act;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ldst_control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ack(mem_ack), .stop(stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout), .Cout(Cout), .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Rin(Rin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .alu_add(alu_add),
        .run(run), .mem_err(mem_err), .illegal_op(illegal_op)
    );

    assign act = {PCout, Zlowout, MDRout, BAout, Cout, Rout, PCin, MARin, MDRin, IRin,
                  Yin, Zlowin, Rin, IncPC, Read, Write, Gra, Grb, alu_add};

    localparam logic [18:0] M_PCOUT = 19'd1 << 18, M_ZLOWOUT = 19'd1 << 17, M_MDROUT = 19'd1 << 16;
    localparam logic [18:0] M_BAOUT = 19'd1 << 15, M_COUT = 19'd1 << 14, M_ROUT = 19'd1 << 13;
    localparam logic [18:0] M_PCIN = 19'd1 << 12, M_MARIN = 19'd1 << 11, M_MDRIN = 19'd1 << 10;
    localparam logic [18:0] M_IRIN = 19'd1 << 9, M_YIN = 19'd1 << 8, M_ZLOWIN = 19'd1 << 7;
    localparam logic [18:0] M_RIN = 19'd1 << 6, M_INCPC = 19'd1 << 5, M_READ = 19'd1 << 4;
    localparam logic [18:0] M_WRITE = 19'd1 << 3, M_GRA = 19'd1 << 2, M_GRB = 19'd1 << 1, M_ALU = 19'd1;

    localparam logic [18:0] E_0    = '0;
    localparam logic [18:0] E_T0   = M_PCOUT | M_MARIN | M_INCPC | M_PCIN;
    localparam logic [18:0] E_T1   = M_READ | M_MDRIN;
    localparam logic [18:0] E_T2   = M_MDROUT | M_IRIN;
    localparam logic [18:0] E_T3   = M_GRB | M_BAOUT | M_YIN;
    localparam logic [18:0] E_T4   = M_COUT | M_ALU | M_ZLOWIN;
    localparam logic [18:0] E_LD5  = M_ZLOWOUT | M_MARIN;
    localparam logic [18:0] E_LD6  = M_READ | M_MDRIN;
    localparam logic [18:0] E_LD7  = M_MDROUT | M_GRA | M_RIN;
    localparam logic [18:0] E_LDI5 = M_ZLOWOUT | M_GRA | M_RIN;
    localparam logic [18:0] E_ST5  = M_ZLOWOUT | M_MARIN;
    localparam logic [18:0] E_ST6  = M_GRA | M_ROUT | M_MDRIN;
    localparam logic [18:0] E_ST7  = M_WRITE;

    // flags = {run, illegal_op, mem_err}
    localparam logic [2:0] F_RUN = 3'b100, F_ILL = 3'b010, F_ERR = 3'b001;

    localparam logic [31:0] IR_LD   = 32'h0090_0055;
    localparam logic [31:0] IR_LDI  = 32'h0980_0010;
    localparam logic [31:0] IR_ST   = 32'h12A0_0020;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_BAD  = 32'h3800_0000;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        ack;
        logic        stop;
        logic [18:0] es;
        logic [2:0]  ef;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic [31:0] v_ir, input logic v_ack,
                       input logic v_stop, input logic [18:0] es, input logic [2:0] ef);
        vec_t v;
        v.name = name; v.ir = v_ir; v.ack = v_ack; v.stop = v_stop; v.es = es; v.ef = ef;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [18:0] es, input logic [2:0] ef);
        n_cmp++;
        if (act !== es) begin
            n_bad++;
            $display("FAIL %s strobes got %05h want %05h", name, act, es);
        end
        n_cmp++;
        if ({run, illegal_op, mem_err} !== ef) begin
            n_bad++;
            $display("FAIL %s flags{run,ill,err} got %03b want %03b", name, {run, illegal_op, mem_err}, ef);
        end
    endtask

    // Entered at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1
    task automatic step(input string name, input logic [31:0] v_ir, input logic v_ack,
                        input logic v_stop, input logic [18:0] es, input logic [2:0] ef);
        ir = v_ir; mem_ack = v_ack; stop = v_stop;
        @(negedge clock);
        check(name, es, ef);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string name);
        clear = 1'b0; mem_ack = 1'b0; stop = 1'b0; ir = '0;
        @(negedge clock);
        check(name, E_0, 3'b000);
        #1 clear = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic ld_to_ld6(input string tag);
        step({tag, " T0"}, IR_LD, 1'b1, 1'b0, E_T0, F_RUN);
        step({tag, " T1"}, IR_LD, 1'b1, 1'b0, E_T1, F_RUN);
        step({tag, " T2"}, IR_LD, 1'b1, 1'b0, E_T2, F_RUN);
        step({tag, " T3"}, IR_LD, 1'b1, 1'b0, E_T3, F_RUN);
        step({tag, " T4"}, IR_LD, 1'b1, 1'b0, E_T4, F_RUN);
        step({tag, " LD5"}, IR_LD, 1'b1, 1'b0, E_LD5, F_RUN);
    endtask

    initial begin
        add("ld T0",  IR_LD, 1, 0, E_T0, F_RUN);   add("ld T1",  IR_LD, 1, 0, E_T1, F_RUN);
        add("ld T2",  IR_LD, 0, 0, E_T2, F_RUN);   add("ld T3",  IR_LD, 1, 0, E_T3, F_RUN);
        add("ld T4",  IR_LD, 1, 0, E_T4, F_RUN);   add("ld LD5", IR_LD, 1, 0, E_LD5, F_RUN);
        add("ld LD6", IR_LD, 1, 0, E_LD6, F_RUN);  add("ld LD7", IR_LD, 1, 0, E_LD7, F_RUN);
        add("ldi T0", IR_LDI, 1, 0, E_T0, F_RUN);  add("ldi T1", IR_LDI, 1, 0, E_T1, F_RUN);
        add("ldi T2", IR_LDI, 1, 0, E_T2, F_RUN);  add("ldi T3", IR_LDI, 1, 0, E_T3, F_RUN);
        add("ldi T4", IR_LDI, 1, 0, E_T4, F_RUN);  add("ldi LDI5", IR_LDI, 1, 0, E_LDI5, F_RUN);
        add("st T0",  IR_ST, 1, 0, E_T0, F_RUN);   add("st T1",  IR_ST, 1, 0, E_T1, F_RUN);
        add("st T2",  IR_ST, 1, 0, E_T2, F_RUN);   add("st T3",  IR_ST, 1, 0, E_T3, F_RUN);
        add("st T4",  IR_ST, 1, 0, E_T4, F_RUN);   add("st ST5", IR_ST, 0, 0, E_ST5, F_RUN);
        add("st ST6", IR_ST, 0, 0, E_ST6, F_RUN);  add("st ST7", IR_ST, 1, 0, E_ST7, F_RUN);
        add("nop T0", IR_NOP, 1, 0, E_T0, F_RUN);  add("nop T1 w1", IR_NOP, 0, 0, E_T1, F_RUN);
        add("nop T1 w2", IR_NOP, 0, 0, E_T1, F_RUN); add("nop T1 w3", IR_NOP, 0, 0, E_T1, F_RUN);
        add("nop T1 ack", IR_NOP, 1, 0, E_T1, F_RUN); add("nop T2", IR_NOP, 1, 0, E_T2, F_RUN);
        add("nop T3", IR_NOP, 1, 0, E_T3, F_RUN);
        add("bad T0", IR_BAD, 1, 0, E_T0, F_RUN);  add("bad T1", IR_BAD, 1, 0, E_T1, F_RUN);
        add("bad T2", IR_BAD, 1, 0, E_T2, F_RUN);  add("bad T3", IR_BAD, 1, 0, E_T3, F_RUN);
        add("ill T0", IR_ST, 1, 0, E_T0, F_RUN | F_ILL); add("st2 T1", IR_ST, 1, 0, E_T1, F_RUN);
        add("st2 T2", IR_ST, 1, 0, E_T2, F_RUN);   add("st2 T3", IR_ST, 1, 0, E_T3, F_RUN);
        add("st2 T4", IR_ST, 1, 0, E_T4, F_RUN);   add("st2 ST5", IR_ST, 1, 0, E_ST5, F_RUN);
        add("st2 ST6", IR_ST, 1, 0, E_ST6, F_RUN); add("st2 ST7 w1", IR_ST, 0, 1, E_ST7, F_RUN);
        add("st2 ST7 w2", IR_ST, 0, 1, E_ST7, F_RUN); add("st2 ST7 ack", IR_ST, 1, 1, E_ST7, F_RUN);
        add("stop HALT", IR_ST, 1, 0, E_0, 3'b000); add("stop HALT hold", IR_LD, 1, 0, E_0, 3'b000);

        do_reset("reset");
        foreach (tbl[i]) step(tbl[i].name, tbl[i].ir, tbl[i].ack, tbl[i].stop, tbl[i].es, tbl[i].ef);

        // Timeout in LD6: 15 stall cycles then HALT with sticky mem_err
        do_reset("reset2");
        ld_to_ld6("to");
        for (int i = 0; i < 15; i++) step($sformatf("to LD6 stall%0d", i), IR_LD, 1'b0, 1'b0, E_LD6, F_RUN);
        step("to HALT", IR_LD, 1'b1, 1'b0, E_0, F_ERR);
        for (int i = 0; i < 3; i++) step($sformatf("to HALT hold%0d", i), IR_LD, 1'b1, 1'b0, E_0, F_ERR);
        do_reset("reset clears mem_err");

        // Ack on the limit cycle wins
        ld_to_ld6("lim");
        for (int i = 0; i < 14; i++) step($sformatf("lim LD6 stall%0d", i), IR_LD, 1'b0, 1'b0, E_LD6, F_RUN);
        step("lim LD6 ack", IR_LD, 1'b1, 1'b0, E_LD6, F_RUN);
        step("lim LD7", IR_LD, 1'b1, 1'b0, E_LD7, F_RUN);
        step("lim T0", IR_LD, 1'b1, 1'b0, E_T0, F_RUN);

        // halt instruction
        step("halt T1", IR_HALT, 1'b1, 1'b0, E_T1, F_RUN);
        step("halt T2", IR_HALT, 1'b1, 1'b0, E_T2, F_RUN);
        step("halt T3", IR_HALT, 1'b1, 1'b0, E_T3, F_RUN);
        step("halt HALT", IR_HALT, 1'b1, 1'b0, E_0, 3'b000);

        // Asynchronous clear in the middle of LD6
        do_reset("reset3");
        ld_to_ld6("clr");
        ir = IR_LD; mem_ack = 1'b0;
        #2 clear = 1'b0;
        #1 check("clr async LD6", E_0, 3'b000);
        #1 clear = 1'b1;
        @(posedge clock);
        #1;
        step("clr restart T0", IR_LD, 1'b1, 1'b0, E_T0, F_RUN);
        step("clr restart T1", IR_LD, 1'b1, 1'b0, E_T1, F_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
